// File: rtl/lut3_pipe.sv
// Two-stage valid/ready pipeline that evaluates a programmable 3-input truth table per bit lane
// and reports the popcount of each result plus a running count of delivered beats.
module lut3_pipe #(
  parameter int unsigned WIDTH    = 8,
  parameter logic [7:0]  RESET_TT = 8'hB8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_a,
  input  logic [WIDTH-1:0]             in_b,
  input  logic [WIDTH-1:0]             in_c,
  input  logic                         cfg_we,
  input  logic [7:0]                   cfg_tt,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_f,
  output logic [$clog2(WIDTH+1)-1:0]   out_ones,
  input  logic                         cnt_clr,
  output logic [15:0]                  out_count
);

  localparam int unsigned OnesW = $clog2(WIDTH + 1);

  logic [7:0]       tt_q, tt_d;
  logic             run_q;
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_f_q, s1_f_d;
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_f_q, s2_f_d;
  logic [OnesW-1:0] s2_ones_q, s2_ones_d;
  logic [15:0]      count_q, count_d;

  logic [WIDTH-1:0] f_eval;
  logic [OnesW-1:0] s1_ones;
  logic             s2_en;
  logic             in_fire;
  logic             out_fire;

  // S2 can take a new beat when it is empty or its current beat is leaving.
  assign s2_en    = !s2_valid_q || out_ready;
  assign in_ready = run_q && (!s1_valid_q || s2_en);
  assign in_fire  = in_valid && in_ready;
  assign out_fire = s2_valid_q && out_ready;

  assign out_valid = s2_valid_q;
  assign out_f     = s2_f_q;
  assign out_ones  = s2_ones_q;
  assign out_count = count_q;

  always_comb begin
    f_eval = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      f_eval[i] = tt_q[{in_a[i], in_b[i], in_c[i]}];
    end
  end

  always_comb begin
    s1_ones = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      s1_ones = s1_ones + OnesW'(s1_f_q[i]);
    end
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_f_d     = s1_f_q;
    if (in_fire) begin
      s1_valid_d = 1'b1;
      s1_f_d     = f_eval;
    end else if (s2_en) begin
      s1_valid_d = 1'b0;
    end

    s2_valid_d = s2_valid_q;
    s2_f_d     = s2_f_q;
    s2_ones_d  = s2_ones_q;
    if (s2_en) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_f_d    = s1_f_q;
        s2_ones_d = s1_ones;
      end
    end

    // A beat accepted alongside a table write was already evaluated with the old table.
    tt_d = cfg_we ? cfg_tt : tt_q;

    count_d = count_q;
    if (cnt_clr) begin
      count_d = '0;
    end else if (out_fire) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tt_q       <= RESET_TT;
      run_q      <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_f_q     <= '0;
      s2_valid_q <= 1'b0;
      s2_f_q     <= '0;
      s2_ones_q  <= '0;
      count_q    <= '0;
    end else begin
      tt_q       <= tt_d;
      run_q      <= 1'b1;
      s1_valid_q <= s1_valid_d;
      s1_f_q     <= s1_f_d;
      s2_valid_q <= s2_valid_d;
      s2_f_q     <= s2_f_d;
      s2_ones_q  <= s2_ones_d;
      count_q    <= count_d;
    end
  end

endmodule

// File: doc/lut3_pipe.md
LUT3_PIPE -- requirements
Module: lut3_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the number of independent bit lanes evaluated per beat.
REQ-002 The block SHALL have parameter RESET_TT, default 8'hB8, giving the truth table loaded at reset; 8'hB8 encodes F = (A & ~B) | (B & C).
REQ-003 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 Port in_valid, input, 1: an input beat is offered.
REQ-006 Port in_ready, output, 1: the block accepts the beat this cycle.
REQ-007 Ports in_a, in_b, in_c, input, WIDTH each: per-lane operands A, B and C.
REQ-008 Port cfg_we, input, 1: write enable for the truth-table register.
REQ-009 Port cfg_tt, input, 8: new truth table, indexed by {A,B,C}.
REQ-010 Port out_valid, output, 1: a result beat is presented.
REQ-011 Port out_ready, input, 1: the consumer accepts the result.
REQ-012 Port out_f, output, WIDTH: per-lane result.
REQ-013 Port out_ones, output, $clog2(WIDTH+1): number of 1 bits in out_f.
REQ-014 Port cnt_clr, input, 1: synchronous clear of out_count.
REQ-015 Port out_count, output, 16: number of completed output handshakes.

Function
REQ-016 Lane i SHALL compute out_f[i] = tt[{in_a[i], in_b[i], in_c[i]}], where tt is the truth-table register.
REQ-017 The pipeline SHALL have two register stages: S1 holds f and a valid bit; S2 holds f, its popcount and a valid bit.
REQ-018 An input beat SHALL be accepted when in_valid && in_ready.
REQ-019 in_ready SHALL be driven as !s1_valid || (s2 empty or draining); it SHALL be combinational and SHALL NOT depend on in_valid.
REQ-020 S1 SHALL advance into S2 when S2 is empty or out_ready is 1.
REQ-021 With out_ready held at 1, the latency from input acceptance to out_valid SHALL be 2 cycles, at a throughput of 1 beat per cycle.
REQ-022 While out_valid && !out_ready, out_f and out_ones SHALL hold stable, and no beat SHALL be dropped or duplicated.
REQ-023 Beat ordering SHALL be preserved.
REQ-024 The truth table SHALL be applied when the beat enters S1; beats already in flight SHALL keep the table they were evaluated with.
REQ-025 When cfg_we is 1, tt SHALL load cfg_tt on that edge.
REQ-026 A beat accepted in the same cycle as a cfg_we write SHALL use the old table; the new table SHALL apply from the next cycle.
REQ-027 out_ones SHALL be computed in S2 from the S1 result and SHALL be exact for all WIDTH values of 1 or more.
REQ-028 out_count SHALL increment by 1 on each out_valid && out_ready cycle and SHALL wrap from 16'hFFFF to 0.
REQ-029 When cnt_clr coincides with a handshake, the clear SHALL win and out_count SHALL become 0.
REQ-030 No input beat SHALL be accepted while the pipeline is full and out_ready is 0.

Reset
REQ-031 When rst_n is 0, the following SHALL take effect immediately, independent of clk: s1_valid = 0, s2_valid = 0, out_valid = 0, out_f = 0, out_ones = 0, out_count = 0, tt = RESET_TT.
REQ-032 While rst_n is 0, in_ready SHALL be 0.
REQ-033 in_ready SHALL become 1 on the first clk edge after rst_n is released.
REQ-034 Reset asserted mid-operation SHALL discard all in-flight beats; none of them SHALL appear after reset.

Verification
REQ-035 Reset-default scenario: WIDTH=8, default table, in_a=8'hF0, in_b=8'hCC, in_c=8'hAA, out_ready=1 -> after 2 cycles out_f=8'hB8, out_ones=4, out_count=1.
REQ-036 Reprogram scenario: write cfg_tt=8'h96 (3-input XOR) in the same cycle as beat X, then send beat Y with identical operands 8'hF0/8'hCC/8'hAA -> X returns 8'hB8 and Y returns 8'h96.
REQ-037 Backpressure scenario: stream 5 beats with out_ready=0 -> in_ready drops after 2 accepts and out_f holds stable; release out_ready -> all 5 beats arrive in order with none lost.
REQ-038 Counter scenario: force 65535 handshakes, then 1 more -> out_count reads 0; then cnt_clr together with a handshake -> out_count reads 0.
REQ-039 Reset-mid-flight scenario: with 2 beats in flight, pulse rst_n low -> out_valid falls to 0 immediately, tt returns to 8'hB8, and no stale beat appears afterwards.
REQ-040 Random scenario: random in_valid/out_ready with WIDTH=1 and WIDTH=13 -> every output matches a reference model applying the truth table captured at acceptance.
